// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter and its VGA master, CPU master and RAM.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_arbiter_if;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  logic [ADDR_W-1:0] i_vga_addr;
  logic              i_vga_cs;
  logic              i_vga_access;
  logic [DATA_W-1:0] o_vga_dat;
  logic [ADDR_W-1:0] i_cpu_addr;
  logic [DATA_W-1:0] i_cpu_dat;
  logic              i_cpu_cs;
  logic              i_cpu_we;
  logic [DATA_W-1:0] o_cpu_dat;
  logic              o_cpu_ack;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [DATA_W-1:0] o_ram_dat;
  logic [DATA_W-1:0] i_ram_dat;
  logic              o_ram_cs;
  logic              o_ram_we;
  logic [7:0]        o_cpu_wait_max;
  logic              o_proto_err;

  modport slave (
    input  i_vga_addr, i_vga_cs, i_vga_access, i_cpu_addr, i_cpu_dat,
           i_cpu_cs, i_cpu_we, i_ram_dat,
    output o_vga_dat, o_cpu_dat, o_cpu_ack, o_ram_addr, o_ram_dat,
           o_ram_cs, o_ram_we, o_cpu_wait_max, o_proto_err
  );

  modport master (
    output i_vga_addr, i_vga_cs, i_vga_access, i_cpu_addr, i_cpu_dat,
           i_cpu_cs, i_cpu_we, i_ram_dat,
    input  o_vga_dat, o_cpu_dat, o_cpu_ack, o_ram_addr, o_ram_dat,
           o_ram_cs, o_ram_we, o_cpu_wait_max, o_proto_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: VGA reads win unconditionally, CPU accesses take a
// grant/wait/ack sequence whenever the VGA master leaves the port idle.
module mem_arbiter #(
  parameter int unsigned WAIT_CNT_W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [WAIT_CNT_W-1:0] CNT_MAX = '1;

  state_t                state_q, state_d;
  logic                  grant_c;
  logic                  ram_cs_c, ram_we_c;
  logic [15:0]           ram_addr_c;
  logic [7:0]            ram_dat_c;
  logic                  cpu_rd_q, ack_q, proto_err_q, vga_access_q;
  logic [7:0]            cpu_dat_q;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d, wait_max_q, wait_max_d;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_c) state_d = ST_WAIT;
      ST_WAIT: state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM port steering: VGA first, then a CPU grant, otherwise quiet (all zero)
  always_comb begin
    grant_c    = 1'b0;
    ram_cs_c   = 1'b0;
    ram_we_c   = 1'b0;
    ram_addr_c = '0;
    ram_dat_c  = '0;
    if (bus.i_vga_cs) begin
      ram_cs_c   = 1'b1;
      ram_addr_c = bus.i_vga_addr;
    end else if (state_q == ST_IDLE && bus.i_cpu_cs && i_reset_n) begin
      grant_c    = 1'b1;
      ram_cs_c   = 1'b1;
      ram_we_c   = bus.i_cpu_we;
      ram_addr_c = bus.i_cpu_addr;
      ram_dat_c  = bus.i_cpu_dat;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    wait_max_d = wait_max_q;
    if (grant_c) begin
      wait_cnt_d = '0;
      if (wait_cnt_q > wait_max_q) wait_max_d = wait_cnt_q;
    end else if (state_q == ST_IDLE && bus.i_cpu_cs && wait_cnt_q != CNT_MAX) begin
      wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
    end
  end

  // Read data lands in WAIT: the RAM answers one cycle after the grant
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cpu_rd_q     <= 1'b0;
      ack_q        <= 1'b0;
      cpu_dat_q    <= '0;
      wait_cnt_q   <= '0;
      wait_max_q   <= '0;
      proto_err_q  <= 1'b0;
      vga_access_q <= 1'b1;
    end else begin
      ack_q        <= (state_q == ST_WAIT);
      wait_cnt_q   <= wait_cnt_d;
      wait_max_q   <= wait_max_d;
      vga_access_q <= bus.i_vga_access;
      if (grant_c) cpu_rd_q <= ~bus.i_cpu_we;
      if (state_q == ST_WAIT && cpu_rd_q) cpu_dat_q <= bus.i_ram_dat;
      if (bus.i_vga_cs && !vga_access_q) proto_err_q <= 1'b1;
    end
  end

  assign bus.o_vga_dat      = bus.i_ram_dat;
  assign bus.o_ram_cs       = ram_cs_c;
  assign bus.o_ram_we       = ram_we_c;
  assign bus.o_ram_addr     = ram_addr_c;
  assign bus.o_ram_dat      = ram_dat_c;
  assign bus.o_cpu_dat      = cpu_dat_q;
  assign bus.o_cpu_ack      = ack_q;
  assign bus.o_cpu_wait_max = 8'(wait_max_q);
  assign bus.o_proto_err    = proto_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency RAM model whose
// contents follow a fixed address pattern plus a single-entry write buffer.
module tb_mem_arbiter;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  mem_arbiter_if bus ();

  mem_arbiter #(.WAIT_CNT_W(8)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ram_pat(input logic [15:0] a);
    return a[15:8] + a[7:0] + 8'h14;
  endfunction

  logic        wr_seen = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [7:0]  wr_dat  = '0;

  always @(posedge clk) begin
    if (bus.o_ram_cs) begin
      if (bus.o_ram_we) begin
        wr_seen <= 1'b1;
        wr_addr <= bus.o_ram_addr;
        wr_dat  <= bus.o_ram_dat;
      end
      bus.i_ram_dat <= (wr_seen && wr_addr == bus.o_ram_addr) ? wr_dat
                                                               : ram_pat(bus.o_ram_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full CPU transaction with the VGA master idle: grant, WAIT, ACK, idle
  task automatic cpu_txn(input logic [15:0] a, input logic we, input logic [7:0] d,
                         input logic [7:0] exp_dat, input string tag);
    bus.i_cpu_cs   = 1'b1;
    bus.i_cpu_we   = we;
    bus.i_cpu_addr = a;
    bus.i_cpu_dat  = d;
    @(negedge clk);
    chk({tag, "_grant"}, 32'({bus.o_ram_cs, bus.o_ram_we, bus.o_ram_addr}),
        32'({1'b1, we, a}));
    chk({tag, "_grant_ack"}, 32'(bus.o_cpu_ack), 32'(0));
    tick();
    @(negedge clk);
    chk({tag, "_wait"}, 32'({bus.o_cpu_ack, bus.o_ram_cs}), 32'(0));
    tick();
    @(negedge clk);
    chk({tag, "_ack"}, 32'(bus.o_cpu_ack), 32'(1));
    chk({tag, "_dat"}, 32'(bus.o_cpu_dat), 32'(exp_dat));
    tick();
    bus.i_cpu_cs = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_drop"}, 32'(bus.o_cpu_ack), 32'(0));
    tick();
  endtask

  initial begin
    int acks;
    logic ack_seen;
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    bus.i_vga_addr   = '0;
    bus.i_vga_cs     = 1'b0;
    bus.i_vga_access = 1'b0;
    bus.i_cpu_addr   = 16'h0777;
    bus.i_cpu_dat    = 8'h11;
    bus.i_cpu_cs     = 1'b1;
    bus.i_cpu_we     = 1'b1;
    bus.i_ram_dat    = '0;

    // Reset: registered outputs cleared, CPU never granted, VGA path still live
    tick();
    @(negedge clk);
    chk("rst_regs", 32'({bus.o_cpu_ack, bus.o_cpu_dat, bus.o_cpu_wait_max, bus.o_proto_err}), 32'(0));
    chk("rst_no_grant", 32'({bus.o_ram_cs, bus.o_ram_we, bus.o_ram_addr, bus.o_ram_dat}), 32'(0));
    tick();
    bus.i_vga_cs   = 1'b1;
    bus.i_vga_addr = 16'h4321;
    @(negedge clk);
    chk("rst_vga", 32'({bus.o_ram_cs, bus.o_ram_we, bus.o_ram_addr}), 32'({1'b1, 1'b0, 16'h4321}));
    tick();
    chk("rst_vga_dat", 32'(bus.o_vga_dat), 32'(ram_pat(16'h4321)));
    bus.i_vga_cs = 1'b0;
    bus.i_cpu_cs = 1'b0;
    bus.i_cpu_we = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Plain CPU read
    cpu_txn(16'h1234, 1'b0, 8'h00, 8'h5A, "rd1234");
    chk("rd_wait_max", 32'(bus.o_cpu_wait_max), 32'(0));

    // CPU write colliding with a VGA fetch
    bus.i_vga_access = 1'b1;
    tick();
    bus.i_vga_access = 1'b0;
    bus.i_vga_cs     = 1'b1;
    bus.i_vga_addr   = 16'h0100;
    bus.i_cpu_cs     = 1'b1;
    bus.i_cpu_we     = 1'b1;
    bus.i_cpu_addr   = 16'h2000;
    bus.i_cpu_dat    = 8'hA5;
    @(negedge clk);
    chk("col_vga", 32'({bus.o_ram_cs, bus.o_ram_we, bus.o_ram_addr}), 32'({1'b1, 1'b0, 16'h0100}));
    tick();
    bus.i_vga_cs = 1'b0;
    @(negedge clk);
    chk("col_grant", 32'({bus.o_ram_cs, bus.o_ram_we, bus.o_ram_addr, bus.o_ram_dat}),
        32'({1'b1, 1'b1, 16'h2000, 8'hA5}));
    chk("col_vga_dat", 32'(bus.o_vga_dat), 32'(8'h15));
    tick();
    @(negedge clk);
    chk("col_wait", 32'(bus.o_cpu_ack), 32'(0));
    tick();
    @(negedge clk);
    chk("col_ack", 32'(bus.o_cpu_ack), 32'(1));
    chk("col_wait_max", 32'(bus.o_cpu_wait_max), 32'(1));
    chk("col_dat_kept", 32'(bus.o_cpu_dat), 32'(8'h5A));
    tick();
    bus.i_cpu_cs = 1'b0;
    tick();
    cpu_txn(16'h2000, 1'b0, 8'h00, 8'hA5, "rdback");

    // Character-fetch pattern under continuous CPU reads
    acks           = 0;
    bus.i_cpu_cs   = 1'b1;
    bus.i_cpu_we   = 1'b0;
    bus.i_cpu_addr = 16'h3000;
    for (int c = 0; c < 32; c++) begin
      int p;
      p = c % 8;
      bus.i_vga_access = (p == 0 || p == 4);
      bus.i_vga_cs     = (p == 1 || p == 5);
      bus.i_vga_addr   = 16'h8000 + 16'(c);
      @(negedge clk);
      if (bus.i_vga_cs)
        chk("fetch_own", 32'({bus.o_ram_cs, bus.o_ram_we, bus.o_ram_addr}),
            32'({1'b1, 1'b0, bus.i_vga_addr}));
      if (p == 2 || p == 6)
        chk("fetch_dat", 32'(bus.o_vga_dat), 32'(ram_pat(16'h8000 + 16'(c - 1))));
      ack_seen = bus.o_cpu_ack;
      if (ack_seen) begin
        chk("fetch_cpu_rd", 32'(bus.o_cpu_dat), 32'(ram_pat(bus.i_cpu_addr)));
        acks++;
      end
      tick();
      if (ack_seen) bus.i_cpu_addr = bus.i_cpu_addr + 16'h0011;
    end
    chk("fetch_acks", 32'(acks >= 5), 32'(1));
    chk("fetch_proto", 32'(bus.o_proto_err), 32'(0));

    // Protocol error: cs without a preceding access
    bus.i_cpu_cs     = 1'b0;
    bus.i_vga_cs     = 1'b0;
    bus.i_vga_access = 1'b0;
    tick();
    tick();
    tick();
    bus.i_vga_cs   = 1'b1;
    bus.i_vga_addr = 16'h0F0F;
    @(negedge clk);
    chk("perr_before", 32'(bus.o_proto_err), 32'(0));
    chk("perr_arb", 32'({bus.o_ram_cs, bus.o_ram_addr}), 32'({1'b1, 16'h0F0F}));
    tick();
    bus.i_vga_cs = 1'b0;
    @(negedge clk);
    chk("perr_set", 32'(bus.o_proto_err), 32'(1));
    tick();
    tick();
    tick();
    chk("perr_sticky", 32'(bus.o_proto_err), 32'(1));

    // Reset in the WAIT cycle aborts the read, request restarts on release
    bus.i_cpu_cs   = 1'b1;
    bus.i_cpu_we   = 1'b0;
    bus.i_cpu_addr = 16'h0042;
    @(negedge clk);
    chk("mid_grant", 32'({bus.o_ram_cs, bus.o_ram_addr}), 32'({1'b1, 16'h0042}));
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ack", 32'({bus.o_cpu_ack, bus.o_ram_cs}), 32'(0));
    chk("mid_rst_regs", 32'({bus.o_proto_err, bus.o_cpu_dat, bus.o_cpu_wait_max}), 32'(0));
    tick();
    @(negedge clk);
    chk("mid_rst_ack2", 32'(bus.o_cpu_ack), 32'(0));
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_regrant", 32'({bus.o_ram_cs, bus.o_ram_addr, bus.o_cpu_ack}), 32'({1'b1, 16'h0042, 1'b0}));
    tick();
    @(negedge clk);
    chk("mid_wait", 32'(bus.o_cpu_ack), 32'(0));
    tick();
    @(negedge clk);
    chk("mid_ack", 32'({bus.o_cpu_ack, bus.o_cpu_dat}), 32'({1'b1, 8'h56}));
    tick();
    bus.i_cpu_cs = 1'b0;
    tick();

    // Long VGA burst saturates the wait counter
    bus.i_vga_access = 1'b1;
    tick();
    bus.i_vga_cs     = 1'b1;
    bus.i_vga_addr   = 16'h9000;
    bus.i_cpu_cs     = 1'b1;
    bus.i_cpu_we     = 1'b1;
    bus.i_cpu_addr   = 16'h0050;
    bus.i_cpu_dat    = 8'h77;
    for (int c = 0; c < 300; c++) tick();
    @(negedge clk);
    chk("sat_blocked", 32'({bus.o_ram_we, bus.o_ram_addr}), 32'({1'b0, 16'h9000}));
    chk("sat_max_pre", 32'(bus.o_cpu_wait_max), 32'(0));
    tick();
    bus.i_vga_cs     = 1'b0;
    bus.i_vga_access = 1'b0;
    @(negedge clk);
    chk("sat_grant", 32'({bus.o_ram_cs, bus.o_ram_we, bus.o_ram_addr}), 32'({1'b1, 1'b1, 16'h0050}));
    tick();
    @(negedge clk);
    chk("sat_max", 32'(bus.o_cpu_wait_max), 32'(255));
    tick();
    @(negedge clk);
    chk("sat_ack", 32'(bus.o_cpu_ack), 32'(1));
    chk("sat_proto", 32'(bus.o_proto_err), 32'(0));
    tick();
    bus.i_cpu_cs = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- i_clk  in  1  sole clock; all state changes on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_vga_addr  in  16  VGA master address.
- i_vga_cs  in  1  VGA master access this cycle (read only).
- i_vga_access  in  1  VGA master will assert i_vga_cs next cycle.
- o_vga_dat  out  8  read data to VGA master.
- i_cpu_addr  in  16  CPU address.
- i_cpu_dat  in  8  CPU write data.
- i_cpu_cs  in  1  CPU request, level, held until ack.
- i_cpu_we  in  1  CPU write (1) / read (0).
- o_cpu_dat  out  8  registered CPU read data.
- o_cpu_ack  out  1  one-cycle completion pulse.
- o_ram_addr  out  16  RAM address.
- o_ram_dat  out  8  RAM write data.
- i_ram_dat  in  8  RAM read data, valid one cycle after the RAM samples its address.
- o_ram_cs  out  1  RAM access strobe.
- o_ram_we  out  1  RAM write strobe.
- o_cpu_wait_max  out  8  largest CPU grant wait seen, saturating.
- o_proto_err  out  1  sticky VGA protocol violation flag.
REQ-002 The block SHALL have parameter WAIT_CNT_W, default 8, giving the width of the wait counters.

Function
REQ-003 The VGA master SHALL have absolute priority.
- When i_vga_cs=1: o_ram_cs=1, o_ram_we=0 and o_ram_addr=i_vga_addr, combinationally and in the same cycle.
REQ-004 o_vga_dat SHALL equal i_ram_dat combinationally at all times, with no register.
REQ-005 The FSM SHALL have three states: IDLE, WAIT and ACK.
REQ-006 The block SHALL grant the CPU in a cycle where state=IDLE, i_cpu_cs=1 and i_vga_cs=0.
- In that cycle: o_ram_cs=1, o_ram_addr=i_cpu_addr, o_ram_we=i_cpu_we, o_ram_dat=i_cpu_dat.
- Next state: WAIT.
REQ-007 When IDLE with i_cpu_cs=1 and i_vga_cs=1, the block SHALL stay IDLE and retry every cycle until i_vga_cs=0.
REQ-008 WAIT SHALL last exactly one cycle.
- On a read: o_cpu_dat<=i_ram_dat at the end of WAIT.
- On a write: o_cpu_dat is unchanged.
- Next state: ACK.
REQ-009 In ACK, o_cpu_ack SHALL be 1 for exactly one cycle and the next state SHALL be IDLE.
- i_cpu_cs is ignored in ACK.
- An i_cpu_cs still 1 in the following IDLE cycle is a new request.
REQ-010 Latency from grant cycle to ack cycle SHALL be exactly 2 cycles, for reads and writes.
REQ-011 When not driven by REQ-003 or REQ-006, the RAM outputs SHALL be o_ram_cs=0, o_ram_we=0, o_ram_addr=0, o_ram_dat=0.
REQ-012 The block SHALL never assert o_ram_we during a VGA access.
REQ-013 The block SHALL never grant the CPU in a cycle with i_vga_cs=1.
REQ-014 The block SHALL use the WAIT and ACK states to leave the RAM port free for VGA accesses.
REQ-015 The wait counter SHALL behave as follows:
- Counts cycles with state=IDLE, i_cpu_cs=1 and no grant.
- Saturates at all-ones.
- Clears on grant.
- On grant, o_cpu_wait_max<=max(o_cpu_wait_max, wait counter).
REQ-016 o_proto_err SHALL be set when i_vga_cs=1 and i_vga_access was 0 in the previous cycle.
- It stays 1 until reset.
- It does not alter arbitration.
REQ-017 The CPU request fields SHALL be sampled only in the grant cycle.
- The CPU master SHALL hold addr, we and dat stable while i_cpu_cs=1.

Reset
REQ-018 Asserting i_reset_n=0 SHALL asynchronously force:
- state=IDLE;
- o_cpu_ack=0, o_cpu_dat=0;
- wait counter=0, o_cpu_wait_max=0;
- o_proto_err=0;
- previous-access register=1.
REQ-019 Reset during WAIT or ACK SHALL abort the transaction with no ack pulse.
- After reset release, a still-asserted i_cpu_cs SHALL be treated as a new request.
REQ-020 The combinational RAM and VGA paths SHALL follow REQ-003, REQ-004 and REQ-011 during reset, except that no CPU grant occurs.

Verification
REQ-021 CPU read, no VGA traffic.
- Stimulus: RAM[0x1234]=0x5A; i_cpu_cs=1, we=0, addr=0x1234 in cycle 0.
- Required: grant in cycle 0; o_cpu_ack=1 in cycle 2; o_cpu_dat=0x5A; o_cpu_wait_max=0.
REQ-022 CPU write colliding with VGA.
- Stimulus: i_vga_access=1 in cycle 0; i_vga_cs=1 in cycle 1; CPU write 0xA5 to 0x2000 requested from cycle 1.
- Required: o_ram_addr=VGA address in cycle 1; CPU granted in cycle 2 with o_ram_we=1; ack in cycle 4; o_cpu_wait_max=1.
REQ-023 VGA character-fetch pattern.
- Stimulus: phases access/cs/access/cs every 8 cycles; continuous CPU reads.
- Required: never o_ram_cs driven by the CPU while i_vga_cs=1; o_vga_dat matches RAM each fetch; o_proto_err=0.
REQ-024 Protocol error.
- Stimulus: i_vga_cs=1 with i_vga_access=0 in the prior cycle.
- Required: o_proto_err=1 from the next cycle, held until i_reset_n=0.
REQ-025 Reset mid-transaction.
- Stimulus: i_reset_n=0 in the WAIT cycle, released 2 cycles later with i_cpu_cs=1.
- Required: no ack before release; new grant in the first cycle after release; ack 2 cycles later.
REQ-026 Wait saturation.
- Stimulus: hold i_vga_cs=1 for 300 cycles with a CPU request pending.
- Required: o_cpu_wait_max=255 after the grant.
